mod_counter: RTL

Parametrised modulo up/down counter. Successor to the fixed 4-bit free-running counter: adds configurable width and modulus, direction control, enable, synchronous clear and load, wrap or saturate mode, terminal-count and wrap-event outputs. Sits wherever the design needs a programmable cycle or event counter, e.g. a divider or timeout source, and is driven directly from the top-level clock domain.

---
 rtl/mod_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with clear, load, wrap/saturate modes,
// terminal-count flag and a saturating count of wrap events.
module mod_counter #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MAX        = 15,
  parameter int unsigned WRAP_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_en,
  input  logic                  io_up,
  input  logic                  io_clear,
  input  logic                  io_load,
  input  logic [WIDTH-1:0]      io_load_value,
  input  logic                  io_sat_mode,
  output logic [WIDTH-1:0]      io_count,
  output logic                  io_tc,
  output logic                  io_wrap,
  output logic [WRAP_CNT_W-1:0] io_wrap_count
);

  // One extra bit so MAX = 2^WIDTH-1 compares and increments without aliasing.
  localparam int unsigned          AW      = WIDTH + 1;
  localparam logic [AW-1:0]        MAX_EXT = AW'(MAX);
  localparam logic [WRAP_CNT_W-1:0] WC_MAX = '1;

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_counter: WIDTH must be in 1..32");
    end
    if (MAX < 1 || 64'(MAX) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
      $error("mod_counter: MAX must be in 1..2^WIDTH-1");
    end
    if (WRAP_CNT_W < 1) begin : g_bad_wcw
      $error("mod_counter: WRAP_CNT_W must be at least 1");
    end
  endgenerate

  logic [AW-1:0]         count_ext;
  logic [AW-1:0]         load_ext;
  logic [WIDTH-1:0]      count_d;
  logic                  wrap_d;
  logic [WRAP_CNT_W-1:0] wrap_count_d;

  assign count_ext = {1'b0, io_count};
  assign load_ext  = {1'b0, io_load_value};

  // Terminal count follows the current direction with no register in between.
  assign io_tc = io_up ? (count_ext == MAX_EXT) : (io_count == '0);

  // Next-state: clear > load > count step; wrap is a per-edge event.
  always_comb begin
    count_d      = io_count;
    wrap_d       = 1'b0;
    wrap_count_d = io_wrap_count;
    if (io_clear) begin
      count_d      = '0;
      wrap_count_d = '0;
    end else if (io_load) begin
      count_d = (load_ext > MAX_EXT) ? WIDTH'(MAX_EXT) : io_load_value;
    end else if (io_en) begin
      if (io_up) begin
        if (count_ext < MAX_EXT) begin
          count_d = WIDTH'(count_ext + AW'(1));
        end else if (!io_sat_mode) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (count_ext != '0) begin
          count_d = WIDTH'(count_ext - AW'(1));
        end else if (!io_sat_mode) begin
          count_d = WIDTH'(MAX_EXT);
          wrap_d  = 1'b1;
        end
      end
      if (wrap_d && (io_wrap_count != WC_MAX)) begin
        wrap_count_d = io_wrap_count + WRAP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_count      <= '0;
      io_wrap       <= 1'b0;
      io_wrap_count <= '0;
    end else begin
      io_count      <= count_d;
      io_wrap       <= wrap_d;
      io_wrap_count <= wrap_count_d;
    end
  end

endmodule
